// File: rtl/seg7_event_counter_pkg.sv
// Shared constants for the display-increment path: opcode agreed with the
// processor decode, and the active-low segment patterns {g,f,e,d,c,b,a}.
package seg7_event_counter_pkg;

  localparam logic [4:0] DISPLAY_INC_OPCODE = 5'b11010;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7_decode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_event_counter_bcd_digit.sv
// One decade of the BCD counter; carry_out feeds the next decade's inc_in.
module bcd_digit (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc_in,
  input  logic       clear,
  output logic       carry_out,
  output logic [3:0] value
);

  assign carry_out = (value == 4'd9) && inc_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc_in) begin
      value <= (value == 4'd9) ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/seg7_event_counter.sv
// Counts rising edges of inc_seg7 in a BCD counter and scans the count onto
// a time-multiplexed active-low common-anode 7-segment display.
module seg7_event_counter
  import seg7_event_counter_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inc_seg7,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrapped,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic                  inc_prev;
  logic                  inc_event;
  logic [NUM_DIGITS:0]   carry;
  logic [3:0]            digit [NUM_DIGITS];
  logic [RW-1:0]         refresh;
  logic [IW-1:0]         idx;
  logic [3:0]            sel_val;
  logic                  upper_zero;
  logic                  blank;
  logic [NUM_DIGITS-1:0] an_next;

  assign inc_event = inc_seg7 && !inc_prev;
  assign carry[0]  = inc_event;

  // Ripple carry: a decade steps only when every lower decade is at 9.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clock     (clock),
      .reset     (reset),
      .inc_in    (carry[i]),
      .clear     (clear),
      .carry_out (carry[i+1]),
      .value     (digit[i])
    );
    assign count_bcd[4*i +: 4] = digit[i];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inc_prev <= 1'b0;
      wrapped  <= 1'b0;
    end else begin
      inc_prev <= inc_seg7;
      wrapped  <= !clear && carry[NUM_DIGITS];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      refresh <= '0;
      idx     <= '0;
    end else if (refresh == REF_LAST) begin
      refresh <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      refresh <= refresh + 1'b1;
    end
  end

  // Digit select, anode pattern and leading-zero test without variable
  // array indexing, so non-power-of-two NUM_DIGITS never reads out of range.
  always_comb begin
    sel_val    = '0;
    upper_zero = 1'b1;
    an_next    = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        sel_val    = digit[i];
        an_next[i] = 1'b0;
      end
      if ((IW'(i) >= idx) && (digit[i] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = (BLANK_LZ != 0) && (idx != '0) && upper_zero;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
    end else begin
      an_n  <= an_next;
      seg_n <= blank ? SEG_BLANK : seg7_decode(sel_val);
    end
  end

endmodule

// File: doc/seg7_event_counter.md
Name: seg7_event_counter

Overview:
- Downstream consumer of the processor's inc_seg7 strobe. inc_seg7 is high while the display-increment opcode (5'b11010) sits in the D/X latch, and can stay high for several cycles during multdiv stalls.
- Counts each distinct occurrence as one event in a multi-digit BCD counter.
- Drives a time-multiplexed, active-low common-anode 7-segment display.
- Sits in the wrapper beside the processor.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and anodes (range 1..8).
- REFRESH_DIV, 100000, clock cycles each digit stays lit (>=2; bench uses 4).
- BLANK_LZ, 1, when 1, leading zero digits are blanked; digit 0 is never blanked.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inc_seg7  in  1  increment request level from the processor.
- clear  in  1  synchronous clear of the count.
- count_bcd  out  4*NUM_DIGITS  current count, digit 0 in bits [3:0].
- wrapped  out  1  one-cycle pulse when the count rolls from all-9s to 0.
- an_n  out  NUM_DIGITS  anode enables, active low, one-hot-low.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (reset=0, asynchronous): all registers clear immediately.
  - count_bcd=0, wrapped=0, an_n=all 1s, seg_n=7'h7F.
  - inc_prev=0, refresh counter=0, digit index=0.
- Edge detect: inc_prev registers inc_seg7.
  - An event is inc_seg7=1 && inc_prev=0.
  - A level held N cycles is one event; low for >=1 cycle re-arms.
  - If inc_seg7 is high in the first cycle after reset deasserts, that counts as an event.
- Count update: count_bcd changes on the clock edge that samples the event, so it is visible 1 cycle after the rising edge of inc_seg7.
- Decade chain:
  - Digit i increments when the event is present and digits 0..i-1 are all 9.
  - A digit at 9 that increments goes to 0.
  - Digit values never exceed 9.
- Wrap: an event while all digits are 9 sets all digits to 0 and asserts wrapped for exactly that one following cycle.
- Clear:
  - clear=1 sets count_bcd to 0 on the next edge.
  - Clear takes priority over a simultaneous event; that event is discarded, not deferred.
  - wrapped=0 during clear.
  - inc_prev still updates during clear.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1 and wraps.
  - At the terminal value, the digit index advances, wrapping from NUM_DIGITS-1 to 0.
  - The scan runs independently of counting and clear.
- Output register:
  - an_n and seg_n are registered from the current digit index and the current count_bcd (1-cycle latency).
  - The first digit lights on the first edge after reset release, with an_n bit 0 low.
  - A count change is reflected on seg_n within 1 cycle if that digit is selected.
- Blanking:
  - With BLANK_LZ=1, digit i>0 is blanked (seg_n=7'h7F, anode still driven low) when it and all higher digits are 0.
- Segment codes (active low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - Any other value displays 7'h7F (unreachable).
- Reset mid-operation: asserting reset mid-count or mid-scan returns every output to its reset value asynchronously. No event is recorded while reset is low.

Decomposition:
- Shared package holds:
  - the 10 segment patterns and the blank constant;
  - DISPLAY_INC_OPCODE=5'b11010, so processor decode and this block agree.
- One sub-module: bcd_digit.
  - One decade with inc_in, clear, carry_out=(value==9)&&inc_in, and 4-bit value.
  - Instantiated NUM_DIGITS times in a generate loop.
- Segment decode is a function in the package, not a module.

Test Plan:
- Reset, then inc_seg7 high for 3 cycles, low, high for 1 cycle -> count_bcd goes 0000->0001->0002. Each change appears 1 cycle after the rising edge, with no extra counts during the hold.
- 10 isolated pulses -> count_bcd=16'h0010. After the 9th pulse it reads 16'h0009; the 10th carries into digit 1.
- 9999 pulses, then one more -> count_bcd=16'h0000 and wrapped=1 for exactly 1 cycle. wrapped is 0 at all other times.
- count=16'h0042 with clear=1 and an inc_seg7 rising edge in the same cycle -> count_bcd=0 next cycle. Dropping clear while inc_seg7 is held high gives no count.
- REFRESH_DIV=4, count=16'h0105:
  - an_n cycles 1110,1101,1011,0111, each for 4 cycles.
  - seg_n is 7'h12, 7'h40, 7'h79, 7'h7F (blanked digit 3).
  - Count=0 gives 7'h40 on digit 0 and blank on digits 1-3.
- Assert reset mid-scan with count=16'h0037 -> outputs immediately show count 0, an_n all 1s, seg_n 7'h7F. After release the scan restarts at digit 0.
